multi_ro_rr: RTL

- Parametrised multi-channel readout sequencer for the digitizer.
- Scans N_CH show-ahead channel FIFOs round-robin and moves one bounded burst per grant into the shared output FIFO.
- Each burst is framed as: header word (channel id), data words, trailer word (word count).
- Adds over the single-channel sequencer: channel count, burst limit, output-FIFO backpressure, trailer.

---
 rtl/multi_ro_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/multi_ro_rr.sv | 136 +++++++++++++
 3 files changed

// File: rtl/multi_ro_pkg.sv
// Shared types and helpers for the multi-channel readout sequencer.
package multi_ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_READOUT = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_HDR = 2'b01;
    localparam logic [1:0] TYPE_DAT = 2'b00;
    localparam logic [1:0] TYPE_TRL = 2'b11;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin channel picker: first requester after 'last', wrapping modulo N_CH.
module rr_arbiter
    import multi_ro_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned IDX_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    int unsigned idx;

    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        grant_o = '0;
        valid_o = |req_i;
        idx     = 0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (32'(last_i) + 32'(i)) % N_CH;
            for (int k = 0; k < N_CH; k++) begin
                if (req_i[k] && (32'(k) == idx)) begin
                    grant_o = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/multi_ro_rr.sv
// Round-robin readout sequencer: moves framed bursts (header, data, trailer)
// from N_CH show-ahead channel FIFOs into one output FIFO.
module multi_ro_rr
    import multi_ro_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 64,
    localparam int unsigned IDX_W    = clog2(N_CH),
    localparam int unsigned CNT_W    = clog2(MAX_BURST + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_CH-1:0]          DAVAIL,
    input  logic [N_CH*DATA_W-1:0]   CH_DATA,
    output logic [N_CH-1:0]          RD_EN,
    input  logic                     FULL,
    output logic                     WR_EN,
    output logic [DATA_W+1:0]        WR_DATA,
    output logic [IDX_W-1:0]         CHSEL,
    output logic                     BUSY
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   chsel_q, chsel_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic [N_CH-1:0]    sel_oh;
    logic               cur_avail;
    logic [DATA_W-1:0]  cur_word;
    logic               at_max;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i   (DAVAIL),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // Decode the granted channel once; every per-channel select goes through it.
    always_comb begin
        sel_oh   = '0;
        cur_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            sel_oh[k] = (IDX_W'(k) == chsel_q);
            if (sel_oh[k]) begin
                cur_word = CH_DATA[k*DATA_W +: DATA_W];
            end
        end
        cur_avail = |(DAVAIL & sel_oh);
        at_max    = (count_q == CNT_W'(MAX_BURST));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            chsel_q <= '0;
            last_q  <= IDX_W'(N_CH - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            chsel_q <= chsel_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Next state and strobes; a data write and its channel pop always go together.
    always_comb begin
        state_d = state_q;
        chsel_d = chsel_q;
        last_d  = last_q;
        count_d = count_q;
        RD_EN   = '0;
        WR_EN   = 1'b0;
        WR_DATA = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    chsel_d = arb_grant;
                    last_d  = arb_grant;
                    count_d = '0;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!FULL) begin
                    WR_EN   = 1'b1;
                    WR_DATA = {TYPE_HDR, DATA_W'(chsel_q)};
                    state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (!cur_avail || at_max) begin
                    state_d = ST_TRAILER;
                end else if (!FULL) begin
                    WR_EN   = 1'b1;
                    RD_EN   = sel_oh;
                    WR_DATA = {TYPE_DAT, cur_word};
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_TRAILER: begin
                if (!FULL) begin
                    WR_EN   = 1'b1;
                    WR_DATA = {TYPE_TRL, DATA_W'(count_q)};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign CHSEL = chsel_q;
    assign BUSY  = (state_q != ST_IDLE);

`ifndef SYNTHESIS
    function automatic string state_name(input state_t s);
        case (s)
            ST_IDLE:    return "IDLE";
            ST_HEADER:  return "HEADER";
            ST_READOUT: return "READOUT";
            ST_TRAILER: return "TRAILER";
            default:    return "UNKNOWN";
        endcase
    endfunction
`endif

endmodule
